// File: rtl/immediate_generator.sv
// ---------------------------------------------------------------------------
// immediate_generator
//
// Decodes the immediate field of a RISC-V instruction word. The decoded
// result {imm, fmt, illegal} is queued in a two-entry in-order buffer. The
// head entry of that buffer drives the outputs.
//
// Parameters
//   XLEN        immediate width, 32 or 64
//   FIFO_DEPTH  number of buffer entries (only 2 is supported)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; overrides flush and handshakes
//   flush        synchronous buffer clear; overrides a push or pop in the same cycle
//   in_valid     an instruction is offered on 'instruction'
//   in_ready     the buffer has a free entry (depends only on occupancy)
//   instruction  32-bit RISC-V instruction word
//   out_valid    the buffer holds at least one result
//   out_ready    the consumer takes the head result this cycle
//   imm          extended immediate of the head entry (0 when empty)
//   fmt          format code of the head entry: 0=R 1=I 2=S 3=B 4=U 5=J 7=ILLEGAL
//   illegal      the head entry came from an unrecognised opcode
// ---------------------------------------------------------------------------
module immediate_generator #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd7
  } immFormatT;

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            isShift;
  immFormatT       decFmt;
  logic [XLEN-1:0] decImm;

  logic [XLEN-1:0] immMemQ [0:1];
  immFormatT       fmtMemQ [0:1];
  logic            illMemQ [0:1];

  logic [1:0] countQ, countD;
  logic       wrPtrQ, wrPtrD;
  logic       rdPtrQ, rdPtrD;
  logic       push, pop;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  // Shift-immediate opcodes reuse the I-type field, but only the shamt bits
  // belong in imm; the funct7/funct6 bits above it must be dropped. The
  // 32-bit-word variant (0011011) only exists on RV64.
  assign isShift = ((funct3 == 3'b001) || (funct3 == 3'b101)) &&
                   ((opcode == 7'b0010011) ||
                    ((opcode == 7'b0011011) && (XLEN == 64)));

  always_comb begin
    decFmt = FMT_ILLEGAL;
    decImm = '0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: decFmt = FMT_I;
      7'b0011011: if (XLEN == 64) decFmt = FMT_I;
      7'b0100011: decFmt = FMT_S;
      7'b1100011: decFmt = FMT_B;
      7'b0110111, 7'b0010111: decFmt = FMT_U;
      7'b1101111: decFmt = FMT_J;
      7'b0110011: decFmt = FMT_R;
      7'b0111011: if (XLEN == 64) decFmt = FMT_R;
      default: decFmt = FMT_ILLEGAL;
    endcase

    case (decFmt)
      FMT_I: decImm = XLEN'($signed(instruction[31:20]));
      FMT_S: decImm = XLEN'($signed({instruction[31:25], instruction[11:7]}));
      FMT_B: decImm = XLEN'($signed({instruction[31], instruction[7],
                                      instruction[30:25], instruction[11:8], 1'b0}));
      FMT_U: decImm = XLEN'($signed({instruction[31:12], 12'b0}));
      FMT_J: decImm = XLEN'($signed({instruction[31], instruction[19:12],
                                      instruction[20], instruction[30:21], 1'b0}));
      default: decImm = '0;
    endcase

    if (isShift) begin
      if ((XLEN == 64) && (opcode == 7'b0010011))
        decImm = XLEN'(instruction[25:20]);
      else
        decImm = XLEN'(instruction[24:20]);
    end
  end

  // Ready comes from registered occupancy alone, so it never combinationally
  // depends on out_ready.
  assign in_ready  = (countQ < DEPTH);
  assign out_valid = (countQ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    countD = countQ;
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    if (flush) begin
      countD = 2'd0;
      wrPtrD = 1'b0;
      rdPtrD = 1'b0;
    end else begin
      if (push) wrPtrD = wrPtrQ + 1'b1;
      if (pop)  rdPtrD = rdPtrQ + 1'b1;
      case ({push, pop})
        2'b10:   countD = countQ + 2'd1;
        2'b01:   countD = countQ - 2'd1;
        default: countD = countQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      countQ <= 2'd0;
      wrPtrQ <= 1'b0;
      rdPtrQ <= 1'b0;
    end else begin
      countQ <= countD;
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
    end
  end

  // Entry storage needs no reset. Occupancy decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      immMemQ[wrPtrQ] <= decImm;
      fmtMemQ[wrPtrQ] <= decFmt;
      illMemQ[wrPtrQ] <= (decFmt == FMT_ILLEGAL);
    end
  end

  // An empty buffer shows the reset values rather than stale entries.
  assign imm     = out_valid ? immMemQ[rdPtrQ] : '0;
  assign fmt     = out_valid ? fmtMemQ[rdPtrQ] : FMT_R;
  assign illegal = out_valid ? illMemQ[rdPtrQ] : 1'b0;

endmodule

// File: tb/tb_immediate_generator.sv
module tb_immediate_generator;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic [31:0] instruction;
  logic        outReady;

  logic        dut32InReady, dut32OutValid, dut32Illegal;
  logic [31:0] dut32Imm;
  logic [2:0]  dut32Fmt;
  logic        dut64InReady, dut64OutValid, dut64Illegal;
  logic [63:0] dut64Imm;
  logic [2:0]  dut64Fmt;

  int checks = 0;
  int errors = 0;
  bit modelReady = 0;
  logic [31:0] modelQ[$];

  localparam logic [6:0] OPS [14] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
                                      7'b0011011, 7'b0100011, 7'b1100011, 7'b0110111,
                                      7'b0010111, 7'b1101111, 7'b0110011, 7'b0111011,
                                      7'b0010011, 7'b0011011};

  immediate_generator #(.XLEN(32), .FIFO_DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(dut32InReady),
    .instruction(instruction), .out_valid(dut32OutValid), .out_ready(outReady),
    .imm(dut32Imm), .fmt(dut32Fmt), .illegal(dut32Illegal));

  immediate_generator #(.XLEN(64), .FIFO_DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(dut64InReady),
    .instruction(instruction), .out_valid(dut64OutValid), .out_ready(outReady),
    .imm(dut64Imm), .fmt(dut64Fmt), .illegal(dut64Illegal));

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
    end
  endtask

  // Reference decoder built from the immediate bit-layout rules using
  // arithmetic on a sign-extended copy of the instruction word
  function automatic void refDecode(input logic [31:0] ins, input int xlen,
                                    output logic [63:0] immOut, output logic [2:0] fmtOut,
                                    output logic illOut);
    longint s;
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    s  = longint'($signed(ins));
    op = ins[6:0];
    f3 = ins[14:12];
    v  = 0;
    fmtOut = 3'd7;
    illOut = 1'b1;
    if (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b1110011 ||
        (op == 7'b0011011 && xlen == 64)) begin
      fmtOut = 3'd1;
      v = s >>> 20;
      if ((f3 == 3'd1 || f3 == 3'd5) && op == 7'b0010011)
        v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      else if ((f3 == 3'd1 || f3 == 3'd5) && op == 7'b0011011)
        v = longint'(ins[24:20]);
    end else if (op == 7'b0100011) begin
      fmtOut = 3'd2;
      v = (s >>> 25) * 32 + longint'(ins[11:7]);
    end else if (op == 7'b1100011) begin
      fmtOut = 3'd3;
      v = (ins[31] ? longint'(-4096) : longint'(0)) + longint'(ins[7]) * 2048 +
          longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
    end else if (op == 7'b0110111 || op == 7'b0010111) begin
      fmtOut = 3'd4;
      v = s - longint'(ins[11:0]);
    end else if (op == 7'b1101111) begin
      fmtOut = 3'd5;
      v = (ins[31] ? longint'(-1048576) : longint'(0)) + longint'(ins[19:12]) * 4096 +
          longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
    end else if (op == 7'b0110011 || (op == 7'b0111011 && xlen == 64)) begin
      fmtOut = 3'd0;
    end
    if (fmtOut != 3'd0 && fmtOut != 3'd7) illOut = 1'b0;
    if (fmtOut == 3'd0) illOut = 1'b0;
    immOut = (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  // Compare both DUTs against the head of the model queue
  task automatic compareAll();
    logic [63:0] eImm32, eImm64;
    logic [2:0]  eFmt32, eFmt64;
    logic        eIll32, eIll64;
    bit          ev;
    ev = (modelQ.size() > 0);
    eImm32 = '0; eImm64 = '0; eFmt32 = '0; eFmt64 = '0; eIll32 = 0; eIll64 = 0;
    if (ev) begin
      refDecode(modelQ[0], 32, eImm32, eFmt32, eIll32);
      refDecode(modelQ[0], 64, eImm64, eFmt64, eIll64);
    end
    checkOutput("out_valid32", {63'b0, dut32OutValid}, {63'b0, ev});
    checkOutput("in_ready32", {63'b0, dut32InReady}, {63'b0, modelQ.size() < 2});
    checkOutput("imm32", {32'b0, dut32Imm}, eImm32);
    checkOutput("fmt32", {61'b0, dut32Fmt}, {61'b0, eFmt32});
    checkOutput("illegal32", {63'b0, dut32Illegal}, {63'b0, eIll32});
    checkOutput("out_valid64", {63'b0, dut64OutValid}, {63'b0, ev});
    checkOutput("in_ready64", {63'b0, dut64InReady}, {63'b0, modelQ.size() < 2});
    checkOutput("imm64", dut64Imm, eImm64);
    checkOutput("fmt64", {61'b0, dut64Fmt}, {61'b0, eFmt64});
    checkOutput("illegal64", {63'b0, dut64Illegal}, {63'b0, eIll64});
  endtask

  // One clock cycle: drive inputs, check current outputs, advance the model
  task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit rdy,
                               input bit fl, input bit rs);
    bit doPop, doPush;
    inValid = v; instruction = ins; outReady = rdy; flush = fl; rst = rs;
    if (modelReady) compareAll();
    @(posedge clk);
    if (rs) begin
      modelQ.delete();
      modelReady = 1;
    end else if (modelReady) begin
      if (fl) modelQ.delete();
      else begin
        doPop  = (modelQ.size() > 0) && rdy;
        doPush = v && (modelQ.size() < 2);
        if (doPop) void'(modelQ.pop_front());
        if (doPush) modelQ.push_back(ins);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 14) r[6:0] = OPS[k];
    return r;
  endfunction

  localparam logic [31:0] INS_A = 32'h00500093;
  localparam logic [31:0] INS_B = 32'hFFF00113;
  localparam logic [31:0] INS_C = 32'h00C00193;

  initial begin
    rst = 1; flush = 0; inValid = 0; instruction = '0; outReady = 0;
    @(negedge clk);
    applyStimulus(0, 32'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 0, 0, 1);

    // Reset state
    checkOutput("reset_in_ready", {63'b0, dut32InReady}, 64'd1);
    checkOutput("reset_out_valid", {63'b0, dut32OutValid}, 64'd0);

    // Known encodings with one-cycle latency
    applyStimulus(1, 32'hFE512E23, 1, 0, 0);
    checkOutput("sw_valid", {63'b0, dut32OutValid}, 64'd1);
    checkOutput("sw_imm", {32'b0, dut32Imm}, 64'h00000000FFFFFFFC);
    checkOutput("sw_fmt", {61'b0, dut32Fmt}, 64'd2);
    checkOutput("sw_illegal", {63'b0, dut32Illegal}, 64'd0);
    applyStimulus(1, 32'hFE000CE3, 1, 0, 0);
    checkOutput("beq_imm", {32'b0, dut32Imm}, 64'h00000000FFFFFFF8);
    checkOutput("beq_fmt", {61'b0, dut32Fmt}, 64'd3);
    applyStimulus(1, 32'h123450B7, 1, 0, 0);
    checkOutput("lui_pos_imm", dut64Imm, 64'h0000000012345000);
    checkOutput("lui_pos_fmt", {61'b0, dut64Fmt}, 64'd4);
    applyStimulus(1, 32'h800000B7, 1, 0, 0);
    checkOutput("lui_neg_imm", dut64Imm, 64'hFFFFFFFF80000000);
    applyStimulus(1, 32'h03F09093, 1, 0, 0);
    checkOutput("slli63_imm", dut64Imm, 64'd63);
    checkOutput("slli63_fmt", {61'b0, dut64Fmt}, 64'd1);
    applyStimulus(1, 32'h4030D093, 1, 0, 0);
    checkOutput("srai3_imm", {32'b0, dut32Imm}, 64'd3);
    applyStimulus(1, 32'h00000000, 1, 0, 0);
    checkOutput("zero_fmt", {61'b0, dut32Fmt}, 64'd7);
    checkOutput("zero_illegal", {63'b0, dut64Illegal}, 64'd1);
    checkOutput("zero_imm", dut64Imm, 64'd0);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Backpressure: two accepts then C is held
    applyStimulus(1, INS_A, 0, 0, 0);
    applyStimulus(1, INS_B, 0, 0, 0);
    checkOutput("bp_full_in_ready", {63'b0, dut32InReady}, 64'd0);
    applyStimulus(1, INS_C, 0, 0, 0);
    checkOutput("bp_stall_imm", {32'b0, dut32Imm}, 64'd5);
    applyStimulus(1, INS_C, 1, 0, 0);
    checkOutput("bp_second_imm", {32'b0, dut32Imm}, 64'h00000000FFFFFFFF);
    applyStimulus(1, INS_C, 1, 0, 0);
    checkOutput("bp_third_imm", {32'b0, dut32Imm}, 64'd12);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Flush while full with a same-cycle push
    applyStimulus(1, INS_A, 0, 0, 0);
    applyStimulus(1, INS_B, 0, 0, 0);
    applyStimulus(1, INS_C, 0, 1, 0);
    checkOutput("flush_out_valid", {63'b0, dut32OutValid}, 64'd0);
    checkOutput("flush_in_ready", {63'b0, dut64InReady}, 64'd1);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Reset mid-stream with one entry held
    applyStimulus(1, INS_A, 0, 0, 0);
    applyStimulus(0, 32'h0, 0, 0, 1);
    checkOutput("rst_out_valid", {63'b0, dut64OutValid}, 64'd0);
    checkOutput("rst_imm", dut64Imm, 64'd0);
    checkOutput("rst_fmt", {61'b0, dut64Fmt}, 64'd0);
    checkOutput("rst_illegal", {63'b0, dut64Illegal}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, dut64InReady}, 64'd1);
    applyStimulus(1, INS_B, 1, 0, 0);
    checkOutput("rst_next_valid", {63'b0, dut64OutValid}, 64'd1);
    checkOutput("rst_next_imm", dut64Imm, 64'hFFFFFFFFFFFFFFFF);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randInstr(), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end
    applyStimulus(0, 32'h0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/immediate_generator.md
IMMEDIATE_GENERATOR -- requirements
Module: immediate_generator

Interface
REQ-001 The block SHALL have a parameter XLEN, default 32, giving the immediate width; legal values are 32 and 64 only.
REQ-002 The block SHALL have a parameter FIFO_DEPTH, fixed at 2, giving the number of output buffer entries; other values are unsupported.
REQ-003 The block SHALL have these ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  synchronous buffer clear.
REQ-006 in_valid  in  1  instruction present.
REQ-007 in_ready  out  1  buffer can accept an instruction.
REQ-008 instruction  in  32  RISC-V instruction word.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 imm  out  XLEN  extended immediate.
REQ-012 fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=ILLEGAL.
REQ-013 illegal  out  1  set when the opcode is unrecognised.

Function
REQ-014 Decoding SHALL use opcode instruction[6:0] as follows:
- I: 0000011, 0010011, 1100111, 1110011; also 0011011, but only when XLEN=64.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
- R: 0110011; also 0111011, but only when XLEN=64.
- Any other opcode SHALL give fmt=7, illegal=1.
REQ-015 I-type immediates SHALL be instruction[31:20], sign-extended to XLEN.
REQ-016 S-type immediates SHALL be {instruction[31:25], instruction[11:7]}, sign-extended to XLEN.
REQ-017 B-type immediates SHALL be {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}, sign-extended to XLEN.
REQ-018 U-type immediates SHALL be {instruction[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
REQ-019 J-type immediates SHALL be {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}, sign-extended to XLEN.
REQ-020 Shift-immediate overrides SHALL apply as follows; funct7/funct6 bits SHALL NOT appear in imm:
- Opcode 0010011 with funct3 001 or 101: imm SHALL be the zero-extended shamt, 5 bits (instruction[24:20]) when XLEN=32, 6 bits (instruction[25:20]) when XLEN=64.
- Opcode 0011011 with funct3 001 or 101: imm SHALL be instruction[24:20] zero-extended.
REQ-021 R-type and ILLEGAL results SHALL carry imm=0.
REQ-022 Decode SHALL be combinational on input; the result {imm, fmt, illegal} SHALL be written into a 2-entry in-order FIFO, with the head entry driving the outputs.
REQ-023 Occupancy count (0..2) SHALL be registered.
- in_ready = (count<2).
- out_valid = (count>0).
- in_ready SHALL NOT depend combinationally on out_ready.
REQ-024 Push SHALL occur when in_valid&&in_ready; pop SHALL occur when out_valid&&out_ready.
REQ-025 Latency SHALL be 1 cycle: an instruction accepted into an empty buffer at edge N SHALL present out_valid=1 with its result after edge N.
REQ-026 Throughput SHALL be 1 result per cycle while out_ready=1.
REQ-027 While out_valid=1 and out_ready=0, imm, fmt and illegal SHALL hold stable.
REQ-028 Simultaneous push and pop at count=1 SHALL leave count at 1, with the older entry popped and the new entry becoming head.
REQ-029 At count=2, in_ready=0, so no push occurs; a pop SHALL reduce count to 1.
REQ-030 Pop at count=0 SHALL be impossible (out_valid=0); push at count=0 with out_ready=1 SHALL still take 1 cycle (no bypass).
REQ-031 Read and write pointers SHALL be 1 bit each and wrap modulo 2.
REQ-032 flush=1 SHALL set count=0 and clear both pointers at the next edge.
- Flush SHALL have priority over a same-cycle push or pop; the pushed instruction is discarded.
- in_ready SHALL follow count in the flush cycle; no additional gating applies.
REQ-033 After flush or reset, out_valid SHALL be 0 and the outputs SHALL show the reset values of REQ-035.

Reset
REQ-034 rst=1 at a rising edge SHALL set count=0 and both pointers to 0; rst SHALL dominate flush and any handshake.
REQ-035 After reset: out_valid=0, imm=0, fmt=0, illegal=0, in_ready=1.
REQ-036 Reset asserted mid-stream SHALL discard all buffered entries; no result from before reset SHALL appear afterwards.

Verification
REQ-037 S-type: XLEN=32, 0xFE512E23 (sw x5,-4(x2)), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFC, fmt=2, illegal=0.
REQ-038 B-type and U-type:
- XLEN=32, 0xFE000CE3 (beq x0,x0,-8) -> imm=0xFFFFFFF8, fmt=3.
- XLEN=64, 0x123450B7 -> imm=0x0000000012345000, fmt=4.
- XLEN=64, 0x800000B7 -> imm=0xFFFFFFFF80000000, fmt=4.
REQ-039 Shift-immediate and illegal:
- XLEN=64, 0x03F09093 (slli x1,x1,63) -> imm=63, fmt=1.
- XLEN=32, 0x4030D093 (srai x1,x1,3) -> imm=3.
- 0x00000000 -> fmt=7, illegal=1, imm=0.
REQ-040 Backpressure: out_ready=0, in_valid=1 for 3 cycles with instructions A, B, C -> in_ready=0 after 2 accepts, C held; then out_ready=1 -> A, B, C delivered in order on consecutive cycles, imm stable while stalled.
REQ-041 Flush: count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the flushed entries and the same-cycle input never appear.
REQ-042 Reset: rst=1 for one cycle with count=1 -> all outputs at reset values; a subsequent instruction decodes with 1-cycle latency.
